// File: rtl/mixer_pkg.sv
// Shared types and constants for the audio mixer: FSM states, default widths,
// and the volume-to-level table.
package mixer_pkg;

    localparam int unsigned DEF_LEVEL_BITS = 8;
    localparam int unsigned DEF_MIX_BITS   = 10;
    localparam int unsigned NUM_CHANNELS   = 3;
    localparam int unsigned VOL_BITS       = 4;
    localparam int unsigned AMP_BITS       = 5;
    localparam int unsigned LUT_BITS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC_A  = 3'd1,
        ST_ACC_B  = 3'd2,
        ST_ACC_C  = 3'd3,
        ST_COMMIT = 3'd4
    } mix_state_e;

    // Roughly 3 dB per step; entry 0 is silence.
    localparam logic [15:0][LUT_BITS-1:0] LEVEL_LUT = {
        8'd255, 8'd180, 8'd128, 8'd90,
        8'd64,  8'd45,  8'd32,  8'd23,
        8'd16,  8'd11,  8'd8,   8'd6,
        8'd4,   8'd3,   8'd2,   8'd0
    };

    // Envelope or fixed volume, forced to silence when the channel gate is closed.
    function automatic logic [VOL_BITS-1:0] effective_vol(
        input logic                gate,
        input logic [AMP_BITS-1:0] amp,
        input logic [VOL_BITS-1:0] env
    );
        logic [VOL_BITS-1:0] vol;
        vol = amp[4] ? env : amp[VOL_BITS-1:0];
        return gate ? vol : '0;
    endfunction

endpackage

// File: rtl/pwm_dac.sv
// Free-running counter PWM: out is high while the counter is below value.
module pwm_dac #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    output logic             out
);

    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic             out_q;
    logic             out_d;

    always_comb begin
        counter_d = counter_q + WIDTH'(1);
        out_d     = (counter_q < value);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            out_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/audio_mixer.sv
// Three-channel mixer: gates and resolves each channel's volume at the sample
// tick, sums log levels over three cycles, and drives a registered sample plus PWM.
module audio_mixer
    import mixer_pkg::*;
#(
    parameter int unsigned LEVEL_BITS = DEF_LEVEL_BITS,
    parameter int unsigned MIX_BITS   = DEF_MIX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [2:0]          tone,
    input  logic                noise,
    input  logic [2:0]          tone_disable,
    input  logic [2:0]          noise_disable,
    input  logic [4:0]          amplitude_a,
    input  logic [4:0]          amplitude_b,
    input  logic [4:0]          amplitude_c,
    input  logic [3:0]          envelope,
    output logic [MIX_BITS-1:0] sample,
    output logic                sample_valid,
    output logic                busy,
    output logic                pwm_out
);

    mix_state_e                                 state_q;
    mix_state_e                                 state_d;
    logic [NUM_CHANNELS-1:0][VOL_BITS-1:0]      vol_q;
    logic [NUM_CHANNELS-1:0][VOL_BITS-1:0]      vol_d;
    logic [MIX_BITS-1:0]                        acc_q;
    logic [MIX_BITS-1:0]                        acc_d;
    logic [MIX_BITS-1:0]                        sample_q;
    logic [MIX_BITS-1:0]                        sample_d;
    logic                                       valid_q;
    logic                                       valid_d;
    logic                                       busy_q;
    logic                                       busy_d;

    logic [NUM_CHANNELS-1:0][AMP_BITS-1:0]      amp_c;
    logic [NUM_CHANNELS-1:0][VOL_BITS-1:0]      snap_vol_c;
    logic [1:0]                                 chan_idx_c;
    logic [LEVEL_BITS-1:0]                      level_c;

    assign amp_c = {amplitude_c, amplitude_b, amplitude_a};

    // Gate each channel and resolve its volume from the live inputs for the snapshot.
    always_comb begin
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            snap_vol_c[i] = effective_vol(
                (tone[i] | tone_disable[i]) & (noise | noise_disable[i]),
                amp_c[i], envelope);
        end
    end

    // Select the channel being accumulated in this state and look up its level.
    always_comb begin
        unique case (state_q)
            ST_ACC_B: chan_idx_c = 2'd1;
            ST_ACC_C: chan_idx_c = 2'd2;
            default:  chan_idx_c = 2'd0;
        endcase
        level_c = LEVEL_BITS'(LEVEL_LUT[vol_q[chan_idx_c]]);
    end

    always_comb begin
        state_d  = state_q;
        vol_d    = vol_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        valid_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    vol_d   = snap_vol_c;
                    acc_d   = '0;
                    state_d = ST_ACC_A;
                end
            end
            ST_ACC_A: begin
                acc_d   = acc_q + MIX_BITS'(level_c);
                state_d = ST_ACC_B;
            end
            ST_ACC_B: begin
                acc_d   = acc_q + MIX_BITS'(level_c);
                state_d = ST_ACC_C;
            end
            ST_ACC_C: begin
                acc_d   = acc_q + MIX_BITS'(level_c);
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                sample_d = acc_q;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy tracks the registered state so enable is ignored until the pass is done.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            vol_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vol_q    <= vol_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

    pwm_dac #(
        .WIDTH (MIX_BITS)
    ) u_pwm_dac (
        .clk   (clk),
        .reset (reset),
        .value (sample_q),
        .out   (pwm_out)
    );

endmodule
